// File: rtl/aes_ctrl_pkg.sv
// Shared AES control definitions: scheduler states, key-size modes, owners,
// and the round count for each key size.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXP_CLR,
        ST_EXPAND,
        ST_READY,
        ST_RUN
    } sched_state_t;

    localparam logic [1:0] AES_MODE_128 = 2'b00;
    localparam logic [1:0] AES_MODE_192 = 2'b01;
    localparam logic [1:0] AES_MODE_256 = 2'b10;

    localparam logic OWNER_ENC = 1'b0;
    localparam logic OWNER_DEC = 1'b1;

    function automatic logic [3:0] nr_for_mode(input logic [1:0] mode);
        if (mode[1])
            return 4'd14;
        else if (mode[0])
            return 4'd12;
        else
            return 4'd10;
    endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-requester round-robin arbiter: req[0]=encrypt, req[1]=decrypt.
// On a tie the requester that did not own the port last time wins.
module aes_rr_arb2
    import aes_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req == 2'b11)
            gnt = (last_owner == OWNER_ENC) ? 2'b10 : 2'b01;
        else
            gnt = req;
    end

endmodule

// File: rtl/aes_rkey_sched.sv
// Round-key store sequencer: runs key expansion on key load, then grants the
// single key read port to the encrypt or decrypt core one block at a time.
module aes_rkey_sched
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned EXP_TIMEOUT = 64,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [1:0]        aes_mode,
    output logic              kexp_rst,
    input  logic              kexp_rdy,
    input  logic              enc_req,
    input  logic              dec_req,
    output logic              enc_gnt,
    output logic              dec_gnt,
    input  logic              rnd_adv,
    output logic [ADDR_W-1:0] rkey_addr,
    output logic              rkey_vld,
    output logic [3:0]        round_idx,
    output logic              first_rnd,
    output logic              last_rnd,
    output logic              blk_done,
    output logic              key_valid,
    output logic              kexp_err
);

    localparam int unsigned TMR_W = $clog2(EXP_TIMEOUT) + 1;

    sched_state_t      state, state_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic              load_pend;
    logic [TMR_W-1:0]  timer;
    logic              key_valid_q, kexp_err_q, last_owner;
    logic              enc_gnt_q, dec_gnt_q, rkey_vld_q, blk_done_q;
    logic [3:0]        round_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        nr;
    logic [1:0]        arb_gnt;
    logic              blk_end, timeout, any_req;

    assign nr      = nr_for_mode(mode_q);
    assign any_req = enc_req | dec_req;
    assign blk_end = (state == ST_RUN) && rnd_adv && (round_q == nr);
    assign timeout = (state == ST_EXPAND) && !kexp_rdy &&
                     (timer == TMR_W'(EXP_TIMEOUT - 1));

    aes_rr_arb2 u_arb (
        .req        ({dec_req, enc_req}),
        .last_owner (last_owner),
        .gnt        (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (key_load) state_nxt = ST_EXP_CLR;
            ST_EXP_CLR: state_nxt = key_load ? ST_EXP_CLR : ST_EXPAND;
            ST_EXPAND: begin
                if (key_load)      state_nxt = ST_EXP_CLR;
                else if (kexp_rdy) state_nxt = ST_READY;
                else if (timeout)  state_nxt = ST_IDLE;
            end
            ST_READY: begin
                if (key_load)     state_nxt = ST_EXP_CLR;
                else if (any_req) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (blk_end)
                    state_nxt = (load_pend || key_load) ? ST_EXP_CLR : ST_READY;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= AES_MODE_128;
            mode_nxt    <= AES_MODE_128;
            load_pend   <= 1'b0;
            timer       <= '0;
            key_valid_q <= 1'b0;
            kexp_err_q  <= 1'b0;
            last_owner  <= OWNER_DEC;
            enc_gnt_q   <= 1'b0;
            dec_gnt_q   <= 1'b0;
            rkey_vld_q  <= 1'b0;
            blk_done_q  <= 1'b0;
            round_q     <= '0;
            addr_q      <= '0;
        end else begin
            blk_done_q <= 1'b0;
            timer      <= (state == ST_EXPAND) ? timer + TMR_W'(1) : '0;

            if (key_load && state != ST_RUN) begin
                mode_q      <= aes_mode;
                key_valid_q <= 1'b0;
                kexp_err_q  <= 1'b0;
            end

            if (state == ST_EXPAND && !key_load) begin
                if (kexp_rdy)
                    key_valid_q <= 1'b1;
                else if (timeout)
                    kexp_err_q <= 1'b1;
            end

            if (state == ST_READY && !key_load && any_req) begin
                enc_gnt_q  <= arb_gnt[0];
                dec_gnt_q  <= arb_gnt[1];
                rkey_vld_q <= 1'b1;
                round_q    <= '0;
                addr_q     <= arb_gnt[1] ? ADDR_W'(nr) : '0;
            end

            if (state == ST_RUN) begin
                if (key_load) begin
                    load_pend <= 1'b1;
                    mode_nxt  <= aes_mode;
                end
                if (rnd_adv) begin
                    if (round_q == nr) begin
                        enc_gnt_q  <= 1'b0;
                        dec_gnt_q  <= 1'b0;
                        rkey_vld_q <= 1'b0;
                        blk_done_q <= 1'b1;
                        last_owner <= dec_gnt_q ? OWNER_DEC : OWNER_ENC;
                        round_q    <= '0;
                        addr_q     <= '0;
                        // A load arriving on the final advance is taken directly, skipping mode_nxt.
                        if (load_pend || key_load) begin
                            mode_q      <= key_load ? aes_mode : mode_nxt;
                            load_pend   <= 1'b0;
                            key_valid_q <= 1'b0;
                            kexp_err_q  <= 1'b0;
                        end
                    end else begin
                        round_q <= round_q + 4'd1;
                        addr_q  <= dec_gnt_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
                    end
                end
            end
        end
    end

    assign kexp_rst  = (state == ST_IDLE) || (state == ST_EXP_CLR);
    assign enc_gnt   = enc_gnt_q;
    assign dec_gnt   = dec_gnt_q;
    assign rkey_vld  = rkey_vld_q;
    assign rkey_addr = addr_q;
    assign round_idx = round_q;
    assign first_rnd = rkey_vld_q && (round_q == 4'd0);
    assign last_rnd  = rkey_vld_q && (round_q == nr);
    assign blk_done  = blk_done_q;
    assign key_valid = key_valid_q;
    assign kexp_err  = kexp_err_q;

endmodule
